// File: rtl/mii_pkg.sv
// Shared MII definitions: framer/receiver state encoding, preamble/SFD nibbles
// and the reflected CRC-32 constants used for the Ethernet FCS.
package mii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DLO,
    ST_DHI,
    ST_FCS,
    ST_IFG,
    ST_ABORT
  } mii_state_t;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/mii_crc32_nibble.sv
// Combinational reflected CRC-32 update by one 4-bit nibble (bit 0 first),
// shared by the MII transmit framer and the receiver's FCS checker.
module mii_crc32_nibble
  import mii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc ^ {28'd0, nibble};
    for (int i = 0; i < 4; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY_REFL) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/mii_tx.sv
// MII transmit framer: preamble/SFD, low-nibble-first payload, optional FCS,
// inter-frame gap. Define MII_TX_FCS_EN to append the CRC-32 FCS in hardware.
module mii_tx
  import mii_pkg::*;
#(
  parameter int IFG_NIBBLES      = 24,
  parameter int PREAMBLE_NIBBLES = 15
) (
  input  logic       mii_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic       mii_tx_en,
  output logic [3:0] mii_txd,
  output logic       mii_tx_er
);

  localparam int CW = 16;

  mii_state_t    state;
  logic [CW-1:0] cnt;
  logic [3:0]    hi_q;
  logic          last_q;

  // Ready depends on state alone so the source never sees a combinational loop.
  assign tx_ready    = (state == ST_SFD) || ((state == ST_DHI) && !last_q);
  assign tx_busy     = (state != ST_IDLE);
  assign tx_underrun = (state == ST_ABORT);

`ifdef MII_TX_FCS_EN
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [31:0] fcs_sr;
  logic [3:0]  crc_nib;

  assign crc_nib = (state == ST_DLO) ? hi_q : tx_data[3:0];

  mii_crc32_nibble u_crc (
    .crc      (crc),
    .nibble   (crc_nib),
    .crc_next (crc_next)
  );

  // CRC follows exactly the payload nibbles placed on the pins; restarts on entry to SFD.
  always_ff @(posedge mii_clk or posedge reset) begin
    if (reset) begin
      crc    <= '0;
      fcs_sr <= '0;
    end else begin
      case (state)
        ST_PRE: if (cnt == '0) crc <= CRC32_INIT;
        ST_SFD: if (tx_valid) crc <= crc_next;
        ST_DLO: crc <= crc_next;
        ST_DHI: begin
          if (last_q)        fcs_sr <= (~crc) >> 4;
          else if (tx_valid) crc    <= crc_next;
        end
        ST_FCS:  fcs_sr <= fcs_sr >> 4;
        default: ;
      endcase
    end
  end
`endif

  // Pin registers are loaded on the edge that enters each state.
  always_ff @(posedge mii_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi_q      <= '0;
      last_q    <= 1'b0;
      mii_tx_en <= 1'b0;
      mii_txd   <= '0;
      mii_tx_er <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            state     <= ST_PRE;
            cnt       <= CW'(PREAMBLE_NIBBLES - 1);
            mii_tx_en <= 1'b1;
            mii_txd   <= PREAMBLE_NIBBLE;
          end
        end
        ST_PRE: begin
          if (cnt == '0) begin
            state   <= ST_SFD;
            mii_txd <= SFD_NIBBLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SFD: begin
          if (tx_valid) begin
            state   <= ST_DLO;
            hi_q    <= tx_data[7:4];
            last_q  <= tx_last;
            mii_txd <= tx_data[3:0];
          end else begin
            state     <= ST_ABORT;
            mii_txd   <= '0;
            mii_tx_er <= 1'b1;
          end
        end
        ST_DLO: begin
          state   <= ST_DHI;
          mii_txd <= hi_q;
        end
        ST_DHI: begin
          if (last_q) begin
`ifdef MII_TX_FCS_EN
            state   <= ST_FCS;
            cnt     <= CW'(7);
            mii_txd <= ~crc[3:0];
`else
            state     <= ST_IFG;
            cnt       <= CW'(IFG_NIBBLES - 1);
            mii_tx_en <= 1'b0;
            mii_txd   <= '0;
`endif
          end else if (tx_valid) begin
            state   <= ST_DLO;
            hi_q    <= tx_data[7:4];
            last_q  <= tx_last;
            mii_txd <= tx_data[3:0];
          end else begin
            state     <= ST_ABORT;
            mii_txd   <= '0;
            mii_tx_er <= 1'b1;
          end
        end
`ifdef MII_TX_FCS_EN
        ST_FCS: begin
          if (cnt == '0) begin
            state     <= ST_IFG;
            cnt       <= CW'(IFG_NIBBLES - 1);
            mii_tx_en <= 1'b0;
            mii_txd   <= '0;
          end else begin
            cnt     <= cnt - 1'b1;
            mii_txd <= fcs_sr[3:0];
          end
        end
`endif
        ST_ABORT: begin
          state     <= ST_IFG;
          cnt       <= CW'(IFG_NIBBLES - 1);
          mii_tx_en <= 1'b0;
          mii_txd   <= '0;
          mii_tx_er <= 1'b0;
        end
        ST_IFG: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          mii_tx_en <= 1'b0;
          mii_txd   <= '0;
          mii_tx_er <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mii_tx.sv
// Self-checking bench for mii_tx: random frames compared against a wire-level
// reference (preamble, SFD, payload nibbles, FCS) built from plain arithmetic.
module tb_mii_tx;
  import mii_pkg::*;

  localparam int PRE = 15;
  localparam int IFG = 24;
`ifdef MII_TX_FCS_EN
  localparam bit FCS_ON = 1'b1;
`else
  localparam bit FCS_ON = 1'b0;
`endif

  typedef logic [7:0] byte_q_t[$];
  typedef logic [3:0] nib_q_t[$];
  typedef struct packed {
    logic       en;
    logic [3:0] txd;
    logic       er;
    logic       ready;
    logic       busy;
    logic       underrun;
    logic       valid;
  } sample_t;

  logic       mii_clk  = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = '0;
  logic       tx_valid = 1'b0;
  logic       tx_last  = 1'b0;
  logic       tx_ready, tx_busy, tx_underrun, mii_tx_en, mii_tx_er;
  logic [3:0] mii_txd;

  logic [31:0] ucrc_in = '0;
  logic [31:0] ucrc_out;
  logic [3:0]  unib = '0;

  sample_t trace[$];
  sample_t smp;
  bit      rec = 1'b0;
  int      n_checks = 0;
  int      n_fail = 0;

  mii_tx #(.IFG_NIBBLES(IFG), .PREAMBLE_NIBBLES(PRE)) dut (
    .mii_clk     (mii_clk),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_underrun (tx_underrun),
    .mii_tx_en   (mii_tx_en),
    .mii_txd     (mii_txd),
    .mii_tx_er   (mii_tx_er)
  );

  mii_crc32_nibble u_crc_unit (
    .crc      (ucrc_in),
    .nibble   (unib),
    .crc_next (ucrc_out)
  );

  always #5 mii_clk = ~mii_clk;

  // Pin trace sampled mid-cycle, away from the active edge.
  always @(negedge mii_clk) begin
    if (rec) begin
      smp.en       = mii_tx_en;
      smp.txd      = mii_txd;
      smp.er       = mii_tx_er;
      smp.ready    = tx_ready;
      smp.busy     = tx_busy;
      smp.underrun = tx_underrun;
      smp.valid    = tx_valid;
      trace.push_back(smp);
    end
  end

  function automatic logic [31:0] ref_fcs(input byte_q_t b);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'd0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected nibbles while TX_EN is high (an aborted frame stops after nbytes).
  function automatic nib_q_t model_wire(input byte_q_t b, input int nbytes, input bit fcs);
    nib_q_t      w;
    logic [31:0] f;
    for (int i = 0; i < PRE; i++) w.push_back(4'h5);
    w.push_back(4'hD);
    for (int i = 0; i < nbytes; i++) begin
      w.push_back(b[i][3:0]);
      w.push_back(b[i][7:4]);
    end
    if (fcs) begin
      f = ref_fcs(b);
      for (int k = 0; k < 8; k++) w.push_back(f[4*k +: 4]);
    end
    return w;
  endfunction

  function automatic int first_en(input int from);
    for (int k = from; k < trace.size(); k++) if (trace[k].en) return k;
    return -1;
  endfunction

  function automatic int first_valid();
    for (int k = 0; k < trace.size(); k++) if (trace[k].valid) return k;
    return -1;
  endfunction

  function automatic int run_len(input int s);
    int n = 0;
    if (s < 0) return 0;
    while (s + n < trace.size() && trace[s+n].en) n++;
    return n;
  endfunction

  function automatic int ifg_len(input int e);
    int n = 0;
    while (e + n < trace.size() && !trace[e+n].en && trace[e+n].busy) n++;
    return n;
  endfunction

  function automatic int first_diff(input int s, input nib_q_t w);
    if (s < 0) return 0;
    for (int k = 0; k < w.size(); k++) begin
      if (s + k >= trace.size()) return k;
      if (!trace[s+k].en || trace[s+k].txd !== w[k]) return k;
    end
    return -1;
  endfunction

  function automatic byte_q_t rand_frame(input int n);
    byte_q_t b;
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  // Source model: presents bytes in order; drops tx_valid once stop_at bytes are taken.
  task automatic drive_frame(input byte_q_t b, input int stop_at);
    int i = 0;
    int budget = 0;
    @(posedge mii_clk); #1;
    tx_valid = 1'b1;
    tx_data  = b[0];
    tx_last  = (b.size() == 1);
    forever begin
      @(negedge mii_clk);
      if (tx_ready && tx_valid) i++;
      @(posedge mii_clk); #1;
      if (i == b.size() || (i == stop_at && tx_busy)) break;
      if (i < b.size()) begin
        tx_data = b[i];
        tx_last = (i == b.size() - 1);
      end
      budget++;
      if (budget > 2000) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL drive_timeout: accepted %0d bytes, required %0d", i, b.size());
        break;
      end
    end
    tx_valid = 1'b0;
    tx_data  = '0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge mii_clk);
      k++;
    end while (tx_busy && k < 1000);
    if (tx_busy) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL idle_timeout: tx_busy still %0d after %0d cycles, required 0", tx_busy, k);
    end
  endtask

  task automatic test_reset();
    int rdy = 0;
    int act = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    #12;
    n_checks++;
    if ({mii_tx_en, mii_txd, mii_tx_er} !== 6'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_pins: got en/txd/er %b, required 000000", {mii_tx_en, mii_txd, mii_tx_er});
    end
    n_checks++;
    if ({tx_busy, tx_ready, tx_underrun} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_status: got busy/ready/underrun %b, required 000", {tx_busy, tx_ready, tx_underrun});
    end
    @(negedge mii_clk);
    reset = 1'b0;
    trace.delete();
    rec = 1'b1;
    repeat (100) @(posedge mii_clk);
    @(negedge mii_clk); #1;
    rec = 1'b0;
    foreach (trace[k]) begin
      if (trace[k].ready) rdy++;
      if (trace[k].en || trace[k].busy || trace[k].er) act++;
    end
    n_checks++;
    if (rdy !== 0) begin
      n_fail++;
      $display("[TB] FAIL idle_ready: tx_ready high in %0d cycles, required 0", rdy);
    end
    n_checks++;
    if (act !== 0) begin
      n_fail++;
      $display("[TB] FAIL idle_activity: en/busy/er active in %0d cycles, required 0", act);
    end
  endtask

  task automatic test_crc_unit();
    byte_q_t     b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int h = 0; h < 2; h++) begin
        ucrc_in = c;
        unib    = h == 0 ? b[i][3:0] : b[i][7:4];
        #1;
        c = ucrc_out;
      end
    end
    n_checks++;
    if (~c !== 32'hCBF43926) begin
      n_fail++;
      $display("[TB] FAIL crc_unit: got %08h, required cbf43926", ~c);
    end
  endtask

  task automatic test_single_byte();
    byte_q_t f1 = '{8'hA7};
    byte_q_t f2 = rand_frame(2 + int'($urandom_range(2, 0)));
    nib_q_t  w1 = model_wire(f1, 1, FCS_ON);
    nib_q_t  w2 = model_wire(f2, f2.size(), FCS_ON);
    int v, s, len, e, s2, d;
    trace.delete();
    rec = 1'b1;
    drive_frame(f1, -1);
    drive_frame(f2, -1);
    wait_idle();
    rec = 1'b0;
    v = first_valid();
    s = first_en(0);
    n_checks++;
    if (s !== v + 1) begin
      n_fail++;
      $display("[TB] FAIL preamble_latency: first tx_en at %0d, required %0d", s, v + 1);
    end
    n_checks++;
    if (v + PRE + 2 >= trace.size() || trace[v+PRE+2].txd !== 4'h7 || !trace[v+PRE+2].en) begin
      n_fail++;
      $display("[TB] FAIL byte0_latency: no low nibble 7 at sample %0d, required txd 7 there", v + PRE + 2);
    end
    len = run_len(s);
    n_checks++;
    if (len !== w1.size()) begin
      n_fail++;
      $display("[TB] FAIL single_en_len: got %0d cycles, required %0d", len, w1.size());
    end
    d = first_diff(s, w1);
    n_checks++;
    if (d !== -1) begin
      n_fail++;
      $display("[TB] FAIL single_txd: first wrong nibble at %0d, required %0h", d, w1[d]);
    end
    e = s + len;
    n_checks++;
    if (ifg_len(e) !== IFG) begin
      n_fail++;
      $display("[TB] FAIL single_ifg: got %0d gap cycles, required %0d", ifg_len(e), IFG);
    end
    // Gap before the queued frame is the IFG plus the IDLE cycle that samples tx_valid.
    s2 = first_en(e);
    n_checks++;
    if (s2 - e !== IFG + 1) begin
      n_fail++;
      $display("[TB] FAIL queued_start: tx_en low for %0d cycles, required %0d", s2 - e, IFG + 1);
    end
    d = first_diff(s2, w2);
    n_checks++;
    if (d !== -1 || run_len(s2) !== w2.size()) begin
      n_fail++;
      $display("[TB] FAIL queued_frame: first wrong nibble %0d, run %0d, required -1 and %0d", d, run_len(s2), w2.size());
    end
  endtask

  task automatic test_back_to_back();
    byte_q_t b;
    nib_q_t  w;
    int s, len, d, ens, bad, r, ers;
    bit exp_rdy;
    for (int f = 0; f < 4; f++) begin
      b = (f == 0) ? '{8'h54, 8'hFF, 8'h01} : rand_frame(1 + int'($urandom_range(7, 0)));
      w = model_wire(b, b.size(), FCS_ON);
      trace.delete();
      rec = 1'b1;
      drive_frame(b, -1);
      wait_idle();
      rec = 1'b0;
      s   = first_en(0);
      len = run_len(s);
      d   = first_diff(s, w);
      ens = 0;
      bad = 0;
      ers = 0;
      foreach (trace[k]) begin
        r       = k - s;
        exp_rdy = trace[k].en && s >= 0 && (r == PRE || (r >= PRE + 2 && r <= PRE + 2 * (b.size() - 1) && (r - PRE) % 2 == 0));
        if (trace[k].ready !== exp_rdy) bad++;
        if (trace[k].en) ens++;
        if (trace[k].er || trace[k].underrun) ers++;
      end
      n_checks++;
      if (d !== -1) begin
        n_fail++;
        $display("[TB] FAIL b2b_txd[%0d]: first wrong nibble at %0d, required %0h", f, d, w[d]);
      end
      n_checks++;
      if (len !== w.size() || ens !== w.size()) begin
        n_fail++;
        $display("[TB] FAIL b2b_en[%0d]: run %0d, total %0d, required %0d gapless", f, len, ens, w.size());
      end
      n_checks++;
      if (bad !== 0) begin
        n_fail++;
        $display("[TB] FAIL b2b_ready[%0d]: %0d cycles with wrong tx_ready, required 0", f, bad);
      end
      n_checks++;
      if (ers !== 0) begin
        n_fail++;
        $display("[TB] FAIL b2b_err[%0d]: er/underrun seen %0d cycles, required 0", f, ers);
      end
    end
  endtask

  task automatic test_fcs();
`ifdef MII_TX_FCS_EN
    byte_q_t     b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic [31:0] golden = 32'hCBF43926;
    int s, len, bad;
    trace.delete();
    rec = 1'b1;
    drive_frame(b, -1);
    wait_idle();
    rec = 1'b0;
    s   = first_en(0);
    len = run_len(s);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (s + PRE + 19 + k >= trace.size() || trace[s+PRE+19+k].txd !== golden[4*k +: 4]) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("[TB] FAIL fcs_nibbles: %0d of 8 FCS nibbles wrong, required 0", bad);
    end
    n_checks++;
    if (len !== PRE + 1 + 18 + 8) begin
      n_fail++;
      $display("[TB] FAIL fcs_en_len: got %0d, required %0d", len, PRE + 1 + 18 + 8);
    end
`endif
  endtask

  task automatic test_underrun();
    byte_q_t b;
    nib_q_t  w;
    int stops[2] = '{2, 0};
    int s, len, a, d, und, ers;
    foreach (stops[t]) begin
      b = rand_frame(4);
      w = model_wire(b, stops[t], 1'b0);
      trace.delete();
      rec = 1'b1;
      drive_frame(b, stops[t]);
      wait_idle();
      rec = 1'b0;
      s   = first_en(0);
      len = run_len(s);
      d   = first_diff(s, w);
      a   = s + w.size();
      und = 0;
      ers = 0;
      foreach (trace[k]) begin
        if (trace[k].underrun) und++;
        if (trace[k].er) ers++;
      end
      n_checks++;
      if (d !== -1 || len !== w.size() + 1) begin
        n_fail++;
        $display("[TB] FAIL underrun_wire[%0d]: diff %0d run %0d, required -1 and %0d", stops[t], d, len, w.size() + 1);
      end
      n_checks++;
      if (a >= trace.size() || {trace[a].en, trace[a].er, trace[a].txd, trace[a].underrun} !== 7'b1100001) begin
        n_fail++;
        $display("[TB] FAIL abort_cycle[%0d]: en/er/txd/underrun wrong at %0d, required 1/1/0/1", stops[t], a);
      end
      n_checks++;
      if (und !== 1 || ers !== 1) begin
        n_fail++;
        $display("[TB] FAIL abort_pulse[%0d]: underrun %0d er %0d cycles, required 1 and 1", stops[t], und, ers);
      end
      n_checks++;
      if (ifg_len(s + len) !== IFG) begin
        n_fail++;
        $display("[TB] FAIL abort_ifg[%0d]: got %0d, required %0d", stops[t], ifg_len(s + len), IFG);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    byte_q_t b = rand_frame(3);
    nib_q_t  w = model_wire(b, 3, FCS_ON);
    int k = 0;
    int v, s, d;
    @(posedge mii_clk); #1;
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    tx_last  = 1'b1;
    do begin
      @(negedge mii_clk);
      k++;
    end while (!tx_ready && k < 100);
    @(posedge mii_clk); #1;
    tx_valid = 1'b0;
    n_checks++;
    if (mii_tx_en !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_dlo: tx_en %0d before reset, required 1", mii_tx_en);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({mii_tx_en, mii_txd, mii_tx_er, tx_busy} !== 7'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: en/txd/er/busy %b, required 0000000", {mii_tx_en, mii_txd, mii_tx_er, tx_busy});
    end
    @(negedge mii_clk);
    reset = 1'b0;
    #1;
    trace.delete();
    rec = 1'b1;
    drive_frame(b, -1);
    wait_idle();
    rec = 1'b0;
    v = first_valid();
    s = first_en(0);
    d = first_diff(s, w);
    n_checks++;
    if (s !== v + 1 || v < 0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_start: tx_en at %0d, required %0d", s, v + 1);
    end
    n_checks++;
    if (d !== -1) begin
      n_fail++;
      $display("[TB] FAIL post_reset_frame: first wrong nibble at %0d, required %0h", d, w[d]);
    end
  endtask

  initial begin
    $display("[TB] mii_tx bench start (FCS %0d)", FCS_ON);
    test_reset();
    test_crc_unit();
    test_single_byte();
    test_back_to_back();
    test_fcs();
    test_underrun();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
